shared_debounce_arbiter: RTL and testbench

SHARED_DEBOUNCE_ARBITER -- requirements
Module: shared_debounce_arbiter

---
 rtl/shared_debounce_arbiter.sv | 145 ++++++++++++++
 tb/tb_shared_debounce_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/shared_debounce_arbiter.sv
// Multi-key switch debouncer sharing one interval timer between all keys.
// Each key is synchronized, then a round-robin arbiter hands the single
// down-counter to one pending key at a time. A key whose synchronized level
// stays different from its debounced level for the whole interval has its
// debounced level toggled, with a one-cycle rise or fall tick.
module shared_debounce_arbiter #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INTERVAL_MS = 40,
  parameter int N_KEYS      = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] sw,
  output logic [N_KEYS-1:0] db_level,
  output logic [N_KEYS-1:0] rise_tick,
  output logic [N_KEYS-1:0] fall_tick,
  output logic              busy,
  output logic [2:0]        owner
);

  // Debounce interval in clock cycles.
  localparam int I  = CLK_FREQ_HZ / 1000 * INTERVAL_MS;
  localparam int CW = (I < 2) ? 1 : $clog2(I);
  localparam logic [CW-1:0] LOAD     = CW'(I - 1);
  localparam logic [2:0]    LAST_KEY = 3'(N_KEYS - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Reject parameter sets the timer or owner encoding cannot represent.
  if (I < 2) begin : g_bad_interval
    $error("shared_debounce_arbiter: debounce interval must be at least 2 cycles");
  end
  if (N_KEYS < 2 || N_KEYS > 8) begin : g_bad_keys
    $error("shared_debounce_arbiter: N_KEYS must be in 2..8");
  end

  logic [N_KEYS-1:0] sync_1;
  logic [N_KEYS-1:0] s_sync;
  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        ptr;
  logic [2:0]        owner_q;

  logic [N_KEYS-1:0] pending;
  logic [N_KEYS-1:0] owner_mask;
  logic              owner_pending;
  logic [2:0]        next_ptr;
  logic              grant_valid;
  logic [2:0]        grant_idx;

  // Two-flop synchronizer on every raw switch input.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      s_sync <= '0;
    end else begin
      sync_1 <= sw;
      s_sync <= sync_1;
    end
  end

  assign pending       = s_sync ^ db_level;
  assign owner_mask    = {{(N_KEYS-1){1'b0}}, 1'b1} << owner_q;
  assign owner_pending = |(pending & owner_mask);
  assign next_ptr      = (owner_q >= LAST_KEY) ? 3'd0 : owner_q + 3'd1;

  // Round-robin pick: lowest pending index at or above ptr, else lowest overall.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic          any_hi;
    logic          any_lo;
    logic [2:0]    hi_idx;
    logic [2:0]    lo_idx;
    any_hi = 1'b0;
    any_lo = 1'b0;
    hi_idx = 3'd0;
    lo_idx = 3'd0;
    for (int j = N_KEYS - 1; j >= 0; j--) begin
      if (pending[j]) begin
        any_lo = 1'b1;
        lo_idx = 3'(j);
        if (3'(j) >= ptr) begin
          any_hi = 1'b1;
          hi_idx = 3'(j);
        end
      end
    end
    grant_valid = any_lo;
    grant_idx   = any_hi ? hi_idx : lo_idx;
  end

  // Arbitration FSM, shared timer and debounced level / tick registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= 3'd0;
      owner_q   <= 3'd0;
      db_level  <= '0;
      rise_tick <= '0;
      fall_tick <= '0;
    end else begin
      rise_tick <= '0;
      fall_tick <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_idx;
            cnt     <= LOAD;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!owner_pending) begin
            // Level bounced back before the interval expired: drop the grant.
            state <= ST_IDLE;
            ptr   <= next_ptr;
          end else if (cnt == '0) begin
            state     <= ST_COMMIT;
            db_level  <= db_level ^ owner_mask;
            rise_tick <= owner_mask & ~db_level;
            fall_tick <= owner_mask & db_level;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_COMMIT: begin
          state <= ST_IDLE;
          ptr   <= next_ptr;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == ST_WAIT) || (state == ST_COMMIT);
  assign owner = busy ? owner_q : 3'd0;

endmodule

// File: tb/tb_shared_debounce_arbiter.sv
// Testbench for shared_debounce_arbiter with a 4-cycle debounce interval.
// Directed scenarios with fixed expected timing, then random switch activity,
// all compared each cycle against a timestamp-based reference model.
module tb_shared_debounce_arbiter;

  localparam int NK = 4;
  localparam int IV = 4;   // 1000 Hz / 1000 * 4 ms

  logic          clk;
  logic          reset_n;
  logic [NK-1:0] sw;
  logic [NK-1:0] db_level;
  logic [NK-1:0] rise_tick;
  logic [NK-1:0] fall_tick;
  logic          busy;
  logic [2:0]    owner;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: grants are timestamped by edge number.
  bit [NK-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
  bit          m_owned, m_commit;
  int          m_own, m_ptr;
  longint      edge_n, m_grant;

  shared_debounce_arbiter #(
    .CLK_FREQ_HZ(1000),
    .INTERVAL_MS(4),
    .N_KEYS     (NK)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sw       (sw),
    .db_level (db_level),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .busy     (busy),
    .owner    (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
    m_owned = 0; m_commit = 0; m_own = 0; m_ptr = 0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (m_commit) begin
        m_commit = 0;
        m_owned  = 0;
        m_ptr    = (m_own + 1) % NK;
      end else if (m_owned) begin
        if (m_s2[m_own] == m_db[m_own]) begin
          m_owned = 0;
          m_ptr   = (m_own + 1) % NK;
        end else if (edge_n - m_grant == longint'(IV)) begin
          if (m_db[m_own]) m_fall[m_own] = 1'b1;
          else             m_rise[m_own] = 1'b1;
          m_db[m_own] = ~m_db[m_own];
          m_commit    = 1;
        end
      end else begin
        for (int k = 0; k < NK; k++) begin
          if (!m_owned && m_s2[(m_ptr + k) % NK] != m_db[(m_ptr + k) % NK]) begin
            m_own   = (m_ptr + k) % NK;
            m_owned = 1;
            m_grant = edge_n;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
    edge_n++;
  endtask

  task automatic compare_model();
    check("db_level", 32'(db_level), 32'(m_db));
    check("rise_tick", 32'(rise_tick), 32'(m_rise));
    check("fall_tick", 32'(fall_tick), 32'(m_fall));
    check("busy", 32'(busy), 32'(m_owned));
    check("owner", 32'(owner), m_owned ? 32'(m_own) : 32'd0);
  endtask

  // Advance n rising edges, checking all outputs 1 time unit after each.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_db"},   32'(db_level),  32'd0);
    check({tag, "_rise"}, 32'(rise_tick), 32'd0);
    check({tag, "_fall"}, 32'(fall_tick), 32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
    check({tag, "_own"},  32'(owner),     32'd0);
  endtask

  initial begin
    edge_n  = 0;
    m_grant = 0;
    model_reset();
    sw      = '0;
    reset_n = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk); model_edge();
    @(posedge clk); model_edge();
    #1;
    reset_n = 1'b1;
    cyc(2);

    // Two keys rise together with ptr=0: key 2 then key 3, ptr wraps to 0.
    sw = 4'b1100;
    cyc(7);
    check("rr_first_rise", 32'(rise_tick), 32'h4);
    check("rr_first_db", 32'(db_level), 32'h4);
    cyc(6);
    check("rr_second_rise", 32'(rise_tick), 32'h8);
    check("rr_second_db", 32'(db_level), 32'hC);
    cyc(1);
    sw = 4'b0000;
    cyc(14);
    check("rr_release_db", 32'(db_level), 32'h0);

    // Single key rise: grant at E0+2, commit at E0+6.
    sw = 4'b0001;
    cyc(3);
    check("rise_busy", 32'(busy), 32'd1);
    check("rise_owner", 32'(owner), 32'd0);
    cyc(3);
    check("rise_early", 32'(rise_tick), 32'h0);
    cyc(1);
    check("rise_tick0", 32'(rise_tick), 32'h1);
    check("rise_db0", 32'(db_level), 32'h1);
    cyc(1);
    check("rise_tick_gone", 32'(rise_tick), 32'h0);
    check("rise_idle", 32'(busy), 32'd0);

    // Held release of key 0.
    sw = 4'b0000;
    cyc(7);
    check("fall_tick0", 32'(fall_tick), 32'h1);
    check("fall_db0", 32'(db_level), 32'h0);
    cyc(2);

    // Three-cycle glitch on key 1: granted, then aborted with no tick.
    sw = 4'b0010;
    cyc(3);
    check("glitch_busy", 32'(busy), 32'd1);
    check("glitch_owner", 32'(owner), 32'd1);
    sw = 4'b0000;
    cyc(6);
    check("glitch_db", 32'(db_level), 32'h0);
    check("glitch_idle", 32'(busy), 32'd0);

    // ptr now 2: keys 0 and 3 together serve key 3 first.
    sw = 4'b1001;
    cyc(7);
    check("ptr2_first", 32'(rise_tick), 32'h8);
    cyc(6);
    check("ptr2_second", 32'(rise_tick), 32'h1);
    check("ptr2_db", 32'(db_level), 32'h9);
    sw = 4'b0000;
    cyc(16);

    // Reset in the middle of WAIT, key held high, then re-debounce.
    sw = 4'b0001;
    cyc(5);
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("midreset");
    cyc(2);
    reset_n = 1'b1;
    cyc(6);
    check("postreset_early", 32'(rise_tick), 32'h0);
    cyc(1);
    check("postreset_rise", 32'(rise_tick), 32'h1);
    check("postreset_db", 32'(db_level), 32'h1);
    cyc(2);

    // Random switch activity, including short glitches and contention.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < NK; k++) begin
        if ($urandom_range(0, 15) == 0) sw[k] = ~sw[k];
      end
      cyc(1);
    end
    sw = '0;
    cyc(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
